sn74ls594_sync: RTL and testbench

//  Clock-synchronous model of the 74LS594: 8-bit serial-in shift register feeding an
//  8-bit parallel output (storage) register, with independent clears.
//  sck/rck are slow strobes from glue logic, oversampled by one system clock.

---
 rtl/sn74ls594_sync_pkg.sv | 8 +
 rtl/sn74ls594_sync_edge_rise_det.sv | 23 ++
 rtl/sn74ls594_sync.sv | 111 +++++++++++
 tb/tb_sn74ls594_sync.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sn74ls594_sync_pkg.sv
// Shared definitions for the clock-synchronous 74LS594 model.
package sn74ls594_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef logic [DEFAULT_WIDTH-1:0] stage_t;

endpackage

// File: rtl/sn74ls594_sync_edge_rise_det.sv
// Rising-transition detector for a strobe that is oversampled by clk.
// The pulse is high for the one clk cycle where d is sampled high after low.
// An X/Z on d, or on the previous sample, never produces a pulse.
module edge_rise_det (
  input  logic clk,
  input  logic clear_n,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // Previous-cycle sample. It tracks d during clears too, so no edge appears on release.
  always_ff @(posedge clk) begin
    d_q <= d;
  end

  // One-cycle pulse on a clean low-to-high transition, suppressed while cleared.
  always_comb begin
    pulse = clear_n && (d === 1'b1) && (d_q === 1'b0);
  end

endmodule

// File: rtl/sn74ls594_sync.sv
// Clock-synchronous 74LS594: serial-in shift stage feeding a parallel storage stage.
// Optional macro INPUT_SYNC_EN adds 2-flop synchronizers on sck, rck, ser and rclr
// (+2 clk latency, synchronizer flops cleared by sclr).
module sn74ls594_sync
  import sn74ls594_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             sck,
  input  logic             rclr,
  input  logic             rck,
  input  logic             ser,
  output logic [WIDTH-1:0] q,
  output logic             qh
);

  logic sck_s;
  logic rck_s;
  logic ser_s;
  logic rclr_s;

`ifdef INPUT_SYNC_EN
  logic [1:0] sck_sync_q;
  logic [1:0] rck_sync_q;
  logic [1:0] ser_sync_q;
  logic [1:0] rclr_sync_q;

  // Two-stage synchronizers for the asynchronous glue-logic inputs.
  always_ff @(posedge clk) begin
    if (!sclr) begin
      sck_sync_q  <= '0;
      rck_sync_q  <= '0;
      ser_sync_q  <= '0;
      rclr_sync_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck};
      rck_sync_q  <= {rck_sync_q[0], rck};
      ser_sync_q  <= {ser_sync_q[0], ser};
      rclr_sync_q <= {rclr_sync_q[0], rclr};
    end
  end

  assign sck_s  = sck_sync_q[1];
  assign rck_s  = rck_sync_q[1];
  assign ser_s  = ser_sync_q[1];
  assign rclr_s = rclr_sync_q[1];
`else
  assign sck_s  = sck;
  assign rck_s  = rck;
  assign ser_s  = ser;
  assign rclr_s = rclr;
`endif

  logic sck_rise;
  logic rck_rise;

  edge_rise_det u_sck_det (
    .clk     (clk),
    .clear_n (sclr),
    .d       (sck_s),
    .pulse   (sck_rise)
  );

  edge_rise_det u_rck_det (
    .clk     (clk),
    .clear_n (rclr_s),
    .d       (rck_s),
    .pulse   (rck_rise)
  );

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state for both stages; storage always captures the pre-shift value of sr_q.
  always_comb begin
    sr_d = sr_q;
    q_d  = q_q;
    if (sck_rise) begin
      sr_d = {sr_q[WIDTH-2:0], ser_s};
    end
    if (rck_rise) begin
      q_d = sr_q;
    end
  end

  // Shift stage, cleared by the block reset only.
  always_ff @(posedge clk) begin
    if (!sclr) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Storage stage, cleared by its own clear only (no value before first clear/store).
  always_ff @(posedge clk) begin
    if (!rclr_s) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign qh = sr_q[WIDTH-1];

endmodule

// File: tb/tb_sn74ls594_sync.sv
// Self-checking bench for sn74ls594_sync (default build, inputs used directly).
module tb_sn74ls594_sync;

  logic       clk;
  logic       sclr;
  logic       sck;
  logic       rclr;
  logic       rck;
  logic       ser;
  logic [7:0] q;
  logic       qh;

  int unsigned n_vec;
  int unsigned n_miss;

  sn74ls594_sync #(.WIDTH(8)) dut (
    .clk  (clk),
    .sclr (sclr),
    .sck  (sck),
    .rclr (rclr),
    .rck  (rck),
    .ser  (ser),
    .q    (q),
    .qh   (qh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: integers holding the shift and storage contents.
  int unsigned m_sr;
  int unsigned m_q;
  bit          m_sr_known;
  bit          m_q_known;
  bit          p_sck;
  bit          p_rck;

  initial begin
    m_sr = 0; m_q = 0; m_sr_known = 0; m_q_known = 0; p_sck = 0; p_rck = 0;
  end

  always @(posedge clk) begin
    bit          sck_edge;
    bit          rck_edge;
    int unsigned old_sr;
    sck_edge = (sck === 1'b1) && !p_sck;
    rck_edge = (rck === 1'b1) && !p_rck;
    old_sr   = m_sr;
    if (!sclr) begin
      m_sr = 0;
      m_sr_known = 1;
    end else if (sck_edge) begin
      m_sr = ((m_sr * 2) + (ser ? 1 : 0)) % 256;
    end
    if (!rclr) begin
      m_q = 0;
      m_q_known = 1;
    end else if (rck_edge) begin
      m_q = old_sr;
      m_q_known = m_sr_known;
    end
    p_sck = (sck === 1'b1);
    p_rck = (rck === 1'b1);
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, got, exp, $time);
    end
  endtask

  // Continuous comparison of DUT outputs against the model, 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    if (m_q_known)  check("q_vs_model", q, 8'(m_q));
    if (m_sr_known) check("qh_vs_model", {7'd0, qh}, {7'd0, m_sr[7]});
  end

  task automatic cyc(input logic a_sclr, input logic a_rclr, input logic a_sck,
                     input logic a_rck, input logic a_ser);
    @(negedge clk);
    sclr = a_sclr; rclr = a_rclr; sck = a_sck; rck = a_rck; ser = a_ser;
  endtask

  task automatic sck_pulse(input logic b);
    cyc(1, 1, 0, 0, b); cyc(1, 1, 0, 0, b);
    cyc(1, 1, 1, 0, b); cyc(1, 1, 1, 0, b);
  endtask

  task automatic rck_pulse();
    cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 1, 0); cyc(1, 1, 0, 1, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Literal expectation on the DUT and on the model together.
  task automatic expect_out(input string name, input logic [7:0] eq, input logic eqh);
    settle();
    check({name, "_q"}, q, eq);
    check({name, "_qh"}, {7'd0, qh}, {7'd0, eqh});
    check({name, "_model_q"}, 8'(m_q), eq);
  endtask

  initial begin
    logic n_sclr, n_rclr, n_sck, n_rck, n_ser;
    n_vec = 0; n_miss = 0;
    sclr = 1; rclr = 1; sck = 0; rck = 0; ser = 0;
    repeat (2) @(negedge clk);

    // 1: both clears
    cyc(0, 0, 0, 0, 0);
    expect_out("t1_clear", 8'h00, 1'b0);

    // 2: four ones, store
    repeat (4) sck_pulse(1);
    rck_pulse();
    expect_out("t2_0F", 8'h0F, 1'b0);

    // 3: four more ones; q holds until the store edge
    repeat (4) sck_pulse(1);
    cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    expect_out("t3_hold", 8'h0F, 1'b1);
    cyc(1, 1, 0, 1, 0); cyc(1, 1, 0, 1, 0);
    expect_out("t3_FF", 8'hFF, 1'b1);

    // 4: two zeros
    repeat (2) sck_pulse(0);
    rck_pulse();
    expect_out("t4_FC", 8'hFC, 1'b1);

    // 5: shift-stage reset leaves storage alone
    cyc(0, 1, 0, 0, 0);
    expect_out("t5_keep", 8'hFC, 1'b0);
    rck_pulse();
    expect_out("t5_00", 8'h00, 1'b0);

    // 6: simultaneous strobes store the pre-shift value
    repeat (4) sck_pulse(1);
    cyc(1, 1, 0, 0, 1); cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 1, 1, 1);
    expect_out("t6_same", 8'h0F, 1'b0);
    cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    expect_out("t6_rclr", 8'h00, 1'b0);
    rck_pulse();
    expect_out("t6_1F", 8'h1F, 1'b0);

    // Randomized traffic; rck is held steady whenever sclr is asserted.
    for (int i = 0; i < 3000; i++) begin
      n_sclr = ($urandom_range(0, 24) != 0);
      n_rclr = ($urandom_range(0, 24) != 0);
      n_sck  = ($urandom_range(0, 2) == 0) ? ~sck : sck;
      n_rck  = (n_sclr && $urandom_range(0, 3) == 0) ? ~rck : rck;
      n_ser  = 1'($urandom_range(0, 1));
      cyc(n_sclr, n_rclr, n_sck, n_rck, n_ser);
    end
    cyc(1, 1, 0, 0, 0);
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
